id_decode_pipe: RTL and testbench



---
 rtl/id_pkg.sv | 48 ++++
 rtl/id_scoreboard.sv | 75 +++++++
 rtl/id_decode_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_id_decode_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the ID stage: opcode encoding, instruction field
// positions, execute-command encodings and the decoded control bundle.
// The operand fields of the bundle (val1/val2/st_val/dest) are sized by the
// top-level parameters, so they sit next to id_ctrl_t in id_decode_pipe.
package id_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_ADD   = 4'h1,
      OP_SUB   = 4'h2,
      OP_AND   = 4'h3,
      OP_OR    = 4'h4,
      OP_MOVR  = 4'h5,
      OP_ADDI  = 4'h6,
      OP_MOVI  = 4'h7,
      OP_CMP   = 4'h8,
      OP_LDR   = 4'h9,
      OP_STR   = 4'hA,
      OP_B     = 4'hB,
      OP_BEQ   = 4'hC,
      OP_BNE   = 4'hD,
      OP_ILL_E = 4'hE,
      OP_ILL_F = 4'hF
   } op_e;

   localparam int OP_W    = 4;
   localparam int FIELD_W = 4;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;
   localparam int IMM8_W  = 8;
   localparam int OFF12_W = 12;

   localparam logic [3:0] EXE_NOP = 4'd0;
   localparam logic [3:0] EXE_ADD = 4'd1;
   localparam logic [3:0] EXE_SUB = 4'd2;
   localparam logic [3:0] EXE_AND = 4'd3;
   localparam logic [3:0] EXE_OR  = 4'd4;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       wb_en;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       set_flags;
   } id_ctrl_t;

endpackage

// File: rtl/id_scoreboard.sv
// In-flight writer tracking for the ID stage.
// One pending bit per register plus one flag-pending bit. A set and a clear
// of the same register in one cycle leaves it pending (set wins).
// Optional feature macro: ID_FWD_EN -- a write-back landing on a pending
// source this cycle is reported as forwardable and no longer stalls.
// Ports:
//   set_en/set_idx     mark a register pending (accepted WB_EN instruction)
//   clr_en/clr_idx     write-back retires a register
//   flag_set/flag_clr  flag writer accepted / flags retired
//   src_a*/src_b*      source registers used by the decoding instruction
//   need_flag          decoding instruction reads the zero flag
//   fwd_a/fwd_b        source served from the write-back bus this cycle
//   hazard             decoding instruction must stall
module id_scoreboard
   import id_pkg::*;
#(
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   input  logic                  flag_set,
   input  logic                  flag_clr,
   input  logic                  src_a_en,
   input  logic [REG_ADDR_W-1:0] src_a,
   input  logic                  src_b_en,
   input  logic [REG_ADDR_W-1:0] src_b,
   input  logic                  need_flag,
   output logic                  fwd_a,
   output logic                  fwd_b,
   output logic                  hazard
);

   localparam int DEPTH = 2**REG_ADDR_W;

   logic [DEPTH-1:0] pending_q, pending_d;
   logic             flag_pend_q, flag_pend_d;
   logic             pend_a, pend_b;

   always_comb begin
      pending_d = pending_q;
      if (clr_en) pending_d[clr_idx] = 1'b0;
      if (set_en) pending_d[set_idx] = 1'b1;
      flag_pend_d = flag_pend_q;
      if (flag_clr) flag_pend_d = 1'b0;
      if (flag_set) flag_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         flag_pend_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         flag_pend_q <= flag_pend_d;
      end
   end

   always_comb begin
      pend_a = src_a_en && pending_q[src_a];
      pend_b = src_b_en && pending_q[src_b];
`ifdef ID_FWD_EN
      fwd_a = pend_a && clr_en && (clr_idx == src_a);
      fwd_b = pend_b && clr_en && (clr_idx == src_b);
`else
      fwd_a = 1'b0;
      fwd_b = 1'b0;
`endif
      hazard = (pend_a && !fwd_a) || (pend_b && !fwd_b) || (need_flag && flag_pend_q);
   end

endmodule

// File: rtl/id_decode_pipe.sv
// Pipelined instruction decode stage with hazard scoreboard and ID/EX register.
// Optional feature macro: ID_FWD_EN (write-back bypass into operands).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   IF/ID handshake and instruction
//   rf_rs1/rf_rs2, rf_rd1/rf_rd2 register file read (address combinational)
//   flag_z/flag_valid        zero flag and flag retirement from EX
//   wb_valid/wb_dest/wb_data write-back bus
//   br_taken/br_offset       taken-branch redirect to fetch
//   out_*                    ID/EX bundle with valid/ready handshake
//   stall_cnt                saturating count of hazard-stall cycles
// Read-port usage: port 1 carries rs1 (rd for ADDI/CMP), port 2 carries rs2
// (rs1 for CMP, rd for STR store data).
module id_decode_pipe
   import id_pkg::*;
#(
   parameter int INSTR_W     = 16,
   parameter int DATA_W      = 24,
   parameter int REG_ADDR_W  = 4,
   parameter int EXE_CMD_W   = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_W-1:0]     in_instr,
   output logic [REG_ADDR_W-1:0]  rf_rs1,
   output logic [REG_ADDR_W-1:0]  rf_rs2,
   input  logic [DATA_W-1:0]      rf_rd1,
   input  logic [DATA_W-1:0]      rf_rd2,
   input  logic                   flag_z,
   input  logic                   flag_valid,
   input  logic                   wb_valid,
   input  logic [REG_ADDR_W-1:0]  wb_dest,
   input  logic [DATA_W-1:0]      wb_data,
   output logic                   br_taken,
   output logic [DATA_W-1:0]      br_offset,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXE_CMD_W-1:0]   out_exe_cmd,
   output logic [DATA_W-1:0]      out_val1,
   output logic [DATA_W-1:0]      out_val2,
   output logic [DATA_W-1:0]      out_st_val,
   output logic [REG_ADDR_W-1:0]  out_dest,
   output logic                   out_wb_en,
   output logic                   out_mem_r_en,
   output logic                   out_mem_w_en,
   output logic                   out_set_flags,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   op_e                   op;
   logic [REG_ADDR_W-1:0] f_rd, f_rs1, f_rs2, addr_a, addr_b;
   logic [DATA_W-1:0]     imm_sext, off_sext, opnd_a, opnd_b;
   logic                  use_a, use_b, need_flag, is_taken;
   logic                  v1_from_a, v2_from_b, v2_from_imm, st_from_b;
   id_ctrl_t              ctrl;
   logic                  fwd_a, fwd_b, hazard, accept, issue;

   logic                   out_valid_q, out_valid_d, squash_q, squash_d;
   id_ctrl_t               ctrl_q, ctrl_d;
   logic [DATA_W-1:0]      val1_q, val1_d, val2_q, val2_d, st_q, st_d;
   logic [REG_ADDR_W-1:0]  dest_q, dest_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   // Branch opcodes leave ctrl and all operand selects at zero, so every
   // branch (taken or not) leaves as a NOP bundle.
   always_comb begin
      op       = op_e'(in_instr[INSTR_W-1 -: OP_W]);
      f_rd     = REG_ADDR_W'(in_instr[RD_LSB  +: FIELD_W]);
      f_rs1    = REG_ADDR_W'(in_instr[RS1_LSB +: FIELD_W]);
      f_rs2    = REG_ADDR_W'(in_instr[RS2_LSB +: FIELD_W]);
      imm_sext = {{(DATA_W-IMM8_W){in_instr[IMM8_W-1]}}, in_instr[IMM8_W-1:0]};
      off_sext = {{(DATA_W-OFF12_W){in_instr[OFF12_W-1]}}, in_instr[OFF12_W-1:0]};
      addr_a      = f_rs1;
      addr_b      = f_rs2;
      use_a       = 1'b0;
      use_b       = 1'b0;
      need_flag   = 1'b0;
      is_taken    = 1'b0;
      v1_from_a   = 1'b0;
      v2_from_b   = 1'b0;
      v2_from_imm = 1'b0;
      st_from_b   = 1'b0;
      ctrl        = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            use_a = 1'b1; use_b = 1'b1; v1_from_a = 1'b1; v2_from_b = 1'b1;
            ctrl.wb_en     = 1'b1;
            ctrl.set_flags = (op == OP_SUB);
            ctrl.exe_cmd   = (op == OP_ADD) ? EXE_ADD :
                             (op == OP_SUB) ? EXE_SUB :
                             (op == OP_AND) ? EXE_AND : EXE_OR;
         end
         OP_MOVR: begin
            use_a = 1'b1; v1_from_a = 1'b1;
            ctrl.wb_en = 1'b1; ctrl.exe_cmd = EXE_ADD;
         end
         OP_ADDI: begin
            addr_a = f_rd; use_a = 1'b1; v1_from_a = 1'b1; v2_from_imm = 1'b1;
            ctrl.wb_en = 1'b1; ctrl.exe_cmd = EXE_ADD;
         end
         OP_MOVI: begin
            v2_from_imm = 1'b1;
            ctrl.wb_en = 1'b1; ctrl.exe_cmd = EXE_ADD;
         end
         OP_CMP: begin
            addr_a = f_rd; addr_b = f_rs1;
            use_a = 1'b1; use_b = 1'b1; v1_from_a = 1'b1; v2_from_b = 1'b1;
            ctrl.set_flags = 1'b1; ctrl.exe_cmd = EXE_SUB;
         end
         OP_LDR: begin
            use_a = 1'b1; v1_from_a = 1'b1;
            ctrl.wb_en = 1'b1; ctrl.mem_r_en = 1'b1; ctrl.exe_cmd = EXE_ADD;
         end
         OP_STR: begin
            addr_b = f_rd; use_a = 1'b1; use_b = 1'b1; v1_from_a = 1'b1; st_from_b = 1'b1;
            ctrl.mem_w_en = 1'b1; ctrl.exe_cmd = EXE_ADD;
         end
         OP_B:    is_taken = 1'b1;
         OP_BEQ:  begin need_flag = 1'b1; is_taken = flag_z;  end
         OP_BNE:  begin need_flag = 1'b1; is_taken = !flag_z; end
         default: ;
      endcase
   end

   id_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (issue && ctrl.wb_en),
      .set_idx   (f_rd),
      .clr_en    (wb_valid),
      .clr_idx   (wb_dest),
      .flag_set  (issue && ctrl.set_flags),
      .flag_clr  (flag_valid),
      .src_a_en  (use_a),
      .src_a     (addr_a),
      .src_b_en  (use_b),
      .src_b     (addr_b),
      .need_flag (need_flag),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
      .hazard    (hazard)
   );

   always_comb begin
      opnd_a   = fwd_a ? wb_data : rf_rd1;
      opnd_b   = fwd_b ? wb_data : rf_rd2;
      in_ready = !rst && !hazard && (!out_valid_q || out_ready);
      accept   = in_valid && in_ready;
      // The instruction following a taken branch is consumed but never issued.
      issue    = accept && !squash_q;
      br_taken = issue && is_taken;
      br_offset = br_taken ? off_sext : '0;

      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      val1_d      = val1_q;
      val2_d      = val2_q;
      st_d        = st_q;
      dest_d      = dest_q;
      if (issue) begin
         out_valid_d = 1'b1;
         ctrl_d      = ctrl;
         val1_d      = v1_from_a ? opnd_a : '0;
         val2_d      = v2_from_b ? opnd_b : (v2_from_imm ? imm_sext : '0);
         st_d        = st_from_b ? opnd_b : '0;
         dest_d      = ctrl.wb_en ? f_rd : '0;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      squash_d = accept ? (!squash_q && is_taken) : squash_q;
      stall_d  = (in_valid && hazard && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         val1_q      <= '0;
         val2_q      <= '0;
         st_q        <= '0;
         dest_q      <= '0;
         squash_q    <= 1'b0;
         stall_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         val1_q      <= val1_d;
         val2_q      <= val2_d;
         st_q        <= st_d;
         dest_q      <= dest_d;
         squash_q    <= squash_d;
         stall_q     <= stall_d;
      end
   end

   assign rf_rs1        = rst ? '0 : addr_a;
   assign rf_rs2        = rst ? '0 : addr_b;
   assign out_valid     = out_valid_q;
   assign out_exe_cmd   = EXE_CMD_W'(ctrl_q.exe_cmd);
   assign out_val1      = val1_q;
   assign out_val2      = val2_q;
   assign out_st_val    = st_q;
   assign out_dest      = dest_q;
   assign out_wb_en     = ctrl_q.wb_en;
   assign out_mem_r_en  = ctrl_q.mem_r_en;
   assign out_mem_w_en  = ctrl_q.mem_w_en;
   assign out_set_flags = ctrl_q.set_flags;
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
module tb_id_decode_pipe;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [23:0] v1;
      logic [23:0] v2;
      logic [23:0] st;
      logic [3:0]  dest;
      logic        wb;
      logic        mr;
      logic        mw;
      logic        sf;
   } bun_t;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] in_instr;
   logic [3:0]  rf_rs1, rf_rs2;
   logic [23:0] rf_rd1, rf_rd2;
   logic        flag_z, flag_valid;
   logic        wb_valid;
   logic [3:0]  wb_dest;
   logic [23:0] wb_data;
   logic        br_taken;
   logic [23:0] br_offset;
   logic        out_valid, out_ready;
   logic [3:0]  out_exe_cmd;
   logic [23:0] out_val1, out_val2, out_st_val;
   logic [3:0]  out_dest;
   logic        out_wb_en, out_mem_r_en, out_mem_w_en, out_set_flags;
   logic [15:0] stall_cnt;

   logic [23:0] regs [16];
   int          n_vec = 0;
   int          n_err = 0;

   assign rf_rd1 = regs[rf_rs1];
   assign rf_rd2 = regs[rf_rs2];

   id_decode_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .flag_z(flag_z), .flag_valid(flag_valid),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .br_taken(br_taken), .br_offset(br_offset),
      .out_valid(out_valid), .out_ready(out_ready), .out_exe_cmd(out_exe_cmd),
      .out_val1(out_val1), .out_val2(out_val2), .out_st_val(out_st_val), .out_dest(out_dest),
      .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
      .out_set_flags(out_set_flags), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bun_t got();
      return {out_exe_cmd, out_val1, out_val2, out_st_val, out_dest,
              out_wb_en, out_mem_r_en, out_mem_w_en, out_set_flags};
   endfunction

   // Register value as seen by decode this cycle.
   function automatic logic [23:0] rv(input logic [3:0] r);
`ifdef ID_FWD_EN
      if (wb_valid && wb_dest == r) return wb_data;
`endif
      return regs[r];
   endfunction

   // Instruction semantics: what EX should receive for an instruction.
   function automatic bun_t exp_bundle(input logic [15:0] ins);
      logic [3:0]  rd, rs1, rs2;
      logic [23:0] s8;
      bun_t        b;
      rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
      s8 = {{16{ins[7]}}, ins[7:0]};
      b  = '0;
      case (ins[15:12])
         4'h1: b = '{4'd1, rv(rs1), rv(rs2), 24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h2: b = '{4'd2, rv(rs1), rv(rs2), 24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b1};
         4'h3: b = '{4'd3, rv(rs1), rv(rs2), 24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h4: b = '{4'd4, rv(rs1), rv(rs2), 24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h5: b = '{4'd1, rv(rs1), 24'd0,   24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h6: b = '{4'd1, rv(rd),  s8,      24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h7: b = '{4'd1, 24'd0,   s8,      24'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0};
         4'h8: b = '{4'd2, rv(rd),  rv(rs1), 24'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
         4'h9: b = '{4'd1, rv(rs1), 24'd0,   24'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0};
         4'hA: b = '{4'd1, rv(rs1), 24'd0,   rv(rd), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
         default: b = '0;
      endcase
      return b;
   endfunction

   function automatic logic [15:0] srcs(input logic [15:0] ins);
      logic [15:0] m;
      m = '0;
      case (ins[15:12])
         4'h1, 4'h2, 4'h3, 4'h4: begin m[ins[7:4]] = 1'b1; m[ins[3:0]] = 1'b1; end
         4'h5, 4'h9:             m[ins[7:4]] = 1'b1;
         4'h6:                   m[ins[11:8]] = 1'b1;
         4'h8, 4'hA:             begin m[ins[11:8]] = 1'b1; m[ins[7:4]] = 1'b1; end
         default: ;
      endcase
      return m;
   endfunction

   task automatic half();
      #4;
   endtask

   // Advance one cycle; the bench register file takes the write-back at the edge.
   task automatic next();
      @(posedge clk);
      #1;
      if (wb_valid === 1'b1) regs[wb_dest] = wb_data;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      wb_valid = 1'b0; wb_dest = '0; wb_data = '0; flag_valid = 1'b0; flag_z = 1'b0;
      next(); next();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_instr = 16'hFFFF; out_ready = 1'b1;
      wb_valid = 1'b0; wb_dest = '0; wb_data = '0; flag_valid = 1'b0; flag_z = 1'b1;
      next(); next(); half();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_vec++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL reset_br_taken: got %b want 0", br_taken); end
      n_vec++; if ({rf_rs1, rf_rs2} !== 8'h00) begin n_err++; $display("FAIL reset_rf_addr: got %h want 00", {rf_rs1, rf_rs2}); end
      n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
      n_vec++; if (got() !== bun_t'(0)) begin n_err++; $display("FAIL reset_bundle: got %h want 0", got()); end
   endtask

   task automatic test_back_to_back();
      bun_t e1, e2;
      do_reset();
      in_valid = 1'b1; in_instr = 16'h1123; e1 = exp_bundle(16'h1123);
      half();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
      next();
      in_instr = 16'h2456; e2 = exp_bundle(16'h2456);
      half();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
      n_vec++; if (out_valid !== 1'b1 || got() !== e1) begin n_err++; $display("FAIL b2b_add: got v=%b %h want v=1 %h", out_valid, got(), e1); end
      next();
      in_valid = 1'b0;
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e2) begin n_err++; $display("FAIL b2b_sub: got v=%b %h want v=1 %h", out_valid, got(), e2); end
      next();
   endtask

   task automatic test_movi();
      do_reset();
      in_valid = 1'b1; in_instr = 16'h71FD;
      next();
      in_valid = 1'b0;
      half();
      n_vec++; if ({out_val1, out_val2} !== {24'h000000, 24'hFFFFFD}) begin n_err++; $display("FAIL movi_vals: got %h %h want 000000 fffffd", out_val1, out_val2); end
      n_vec++; if ({out_valid, out_wb_en, out_dest} !== {1'b1, 1'b1, 4'd1}) begin n_err++; $display("FAIL movi_ctrl: got v=%b wb=%b d=%0d want 1 1 1", out_valid, out_wb_en, out_dest); end
      next();
   endtask

   task automatic test_raw_stall();
      logic [23:0] d;
      bun_t        e;
      do_reset();
      d = ~regs[1];
      in_valid = 1'b1; in_instr = 16'h1123;
      next();
      in_instr = 16'h1210;
      for (int i = 0; i < 2; i++) begin
         half();
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_%0d: got in_ready %b want 0", i, in_ready); end
         next();
      end
      wb_valid = 1'b1; wb_dest = 4'd1; wb_data = d;
      half();
`ifdef ID_FWD_EN
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_fwd_ready: got %b want 1", in_ready); end
      next();
      wb_valid = 1'b0; in_valid = 1'b0;
      e = '{4'd1, d, regs[0], 24'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e) begin n_err++; $display("FAIL raw_fwd_bundle: got v=%b %h want v=1 %h", out_valid, got(), e); end
      n_vec++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL raw_stall_cnt: got %0d want 2", stall_cnt); end
`else
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_wb_cycle: got in_ready %b want 0", in_ready); end
      next();
      wb_valid = 1'b0;
      half();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got in_ready %b want 1", in_ready); end
      next();
      in_valid = 1'b0;
      e = '{4'd1, d, regs[0], 24'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e) begin n_err++; $display("FAIL raw_bundle: got v=%b %h want v=1 %h", out_valid, got(), e); end
      n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt); end
`endif
      next();
   endtask

   task automatic test_branch();
      bun_t e;
      do_reset();
      in_valid = 1'b1; in_instr = 16'h8120;
      next();
      in_instr = 16'hC004;
      half();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL beq_wait_flag: got in_ready %b want 0", in_ready); end
      next();
      flag_valid = 1'b1; flag_z = 1'b1;
      half();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL beq_flag_cycle: got in_ready %b want 0", in_ready); end
      next();
      flag_valid = 1'b0;
      half();
      n_vec++; if ({in_ready, br_taken} !== 2'b11) begin n_err++; $display("FAIL beq_taken: got ready=%b taken=%b want 1 1", in_ready, br_taken); end
      n_vec++; if (br_offset !== 24'd4) begin n_err++; $display("FAIL beq_offset: got %h want 000004", br_offset); end
      next();
      in_instr = 16'h1567;
      half();
      n_vec++; if ({out_valid, out_wb_en, out_exe_cmd} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL beq_nop_bundle: got v=%b wb=%b cmd=%0d want 1 0 0", out_valid, out_wb_en, out_exe_cmd); end
      n_vec++; if ({in_ready, br_taken} !== 2'b10) begin n_err++; $display("FAIL squash_accept: got ready=%b taken=%b want 1 0", in_ready, br_taken); end
      next();
      in_instr = 16'h1789; e = exp_bundle(16'h1789);
      half();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL squash_dropped: got out_valid %b want 0", out_valid); end
      next();
      in_valid = 1'b0;
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e) begin n_err++; $display("FAIL after_squash: got v=%b %h want v=1 %h", out_valid, got(), e); end
      next();
   endtask

   task automatic test_backpressure();
      bun_t e1, e2;
      do_reset();
      in_valid = 1'b1; in_instr = 16'h1123; e1 = exp_bundle(16'h1123);
      next();
      out_ready = 1'b0; in_instr = 16'h4456; e2 = exp_bundle(16'h4456);
      for (int i = 0; i < 3; i++) begin
         half();
         n_vec++; if ({out_valid, in_ready} !== 2'b10 || got() !== e1) begin n_err++; $display("FAIL hold_%0d: got v=%b rdy=%b %h want 1 0 %h", i, out_valid, in_ready, got(), e1); end
         next();
      end
      out_ready = 1'b1;
      half();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready: got %b want 1", in_ready); end
      next();
      in_valid = 1'b0;
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e2) begin n_err++; $display("FAIL drain_next: got v=%b %h want v=1 %h", out_valid, got(), e2); end
      next();
      half();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
      next();
   endtask

   task automatic test_reset_mid();
      bun_t e;
      do_reset();
      in_valid = 1'b1; in_instr = 16'h1123;
      next();
      in_instr = 16'h1210;
      half();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got in_ready %b want 0", in_ready); end
      next();
      rst = 1'b1;
      next();
      rst = 1'b0; e = exp_bundle(16'h1210);
      half();
      n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rstmid_clear: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
      next();
      in_valid = 1'b0;
      half();
      n_vec++; if (out_valid !== 1'b1 || got() !== e) begin n_err++; $display("FAIL rstmid_issue: got v=%b %h want v=1 %h", out_valid, got(), e); end
      n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_stall_cnt: got %0d want 0", stall_cnt); end
      next();
   endtask

   // Cycle-level reference: pending set, flag-pending, squash, ID/EX slot.
   task automatic test_random();
      logic [15:0] mpend, fmask, ins;
      logic        mfpend, mvalid, msquash, hz, rdy, acc, taken, exp_br;
      logic [15:0] mstall;
      logic [3:0]  op, r;
      bun_t        mbun, eb;
      do_reset();
      mpend = '0; mfpend = 1'b0; mvalid = 1'b0; msquash = 1'b0; mstall = '0; mbun = '0;
      for (int c = 0; c < 600; c++) begin
         ins = 16'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = ins;
         out_ready = ($urandom_range(0, 3) != 0);
         r = 4'($urandom_range(0, 15));
         wb_valid = mpend[r] && ($urandom_range(0, 1) == 1);
         wb_dest = r; wb_data = 24'($urandom);
         flag_valid = mfpend && ($urandom_range(0, 2) == 0);
         flag_z = 1'($urandom_range(0, 1));
         half();
         op = ins[15:12];
         fmask = '0;
`ifdef ID_FWD_EN
         if (wb_valid) fmask[wb_dest] = 1'b1;
`endif
         hz = |(srcs(ins) & mpend & ~fmask) || ((op == 4'hC || op == 4'hD) && mfpend);
         rdy = !hz && (!mvalid || out_ready);
         acc = in_valid && rdy;
         taken = (op == 4'hB) || (op == 4'hC && flag_z) || (op == 4'hD && !flag_z);
         exp_br = acc && !msquash && taken;
         n_vec++; if (in_ready !== rdy) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, rdy); end
         n_vec++; if (br_taken !== exp_br) begin n_err++; $display("FAIL rnd_br_taken c%0d: got %b want %b", c, br_taken, exp_br); end
         if (exp_br) begin
            n_vec++; if (br_offset !== {{12{ins[11]}}, ins[11:0]}) begin n_err++; $display("FAIL rnd_br_offset c%0d: got %h want %h", c, br_offset, {{12{ins[11]}}, ins[11:0]}); end
         end
         n_vec++; if (out_valid !== mvalid) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, mvalid); end
         if (mvalid) begin
            n_vec++; if (got() !== mbun) begin n_err++; $display("FAIL rnd_bundle c%0d: got %h want %h", c, got(), mbun); end
         end
         n_vec++; if (stall_cnt !== mstall) begin n_err++; $display("FAIL rnd_stall_cnt c%0d: got %0d want %0d", c, stall_cnt, mstall); end
         eb = exp_bundle(ins);
         next();
         if (in_valid && hz && mstall != 16'hFFFF) mstall++;
         if (wb_valid) mpend[wb_dest] = 1'b0;
         if (flag_valid) mfpend = 1'b0;
         if (acc && !msquash) begin
            mvalid = 1'b1;
            mbun = eb;
            if (eb.wb) mpend[ins[11:8]] = 1'b1;
            if (eb.sf) mfpend = 1'b1;
         end else if (out_ready) begin
            mvalid = 1'b0;
         end
         if (acc) msquash = !msquash && taken;
      end
      wb_valid = 1'b0; flag_valid = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 24'($urandom);
      test_reset();
      test_back_to_back();
      test_movi();
      test_raw_stall();
      test_branch();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
